// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side signals of the shared UART transmitter arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_start;
  logic                      tx_busy;
  logic [GW-1:0]             grant_id;
  logic                      tx_done;
  logic                      err_timeout;
  logic                      idle;

  modport slave (
    input  req_valid, req_data, tx_busy,
    output req_ready, tx_data, tx_start, grant_id, tx_done, err_timeout, idle
  );

  modport master (
    output req_valid, req_data, tx_busy,
    input  req_ready, tx_data, tx_start, grant_id, tx_done, err_timeout, idle
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter between NUM_REQ requesters,
// sequencing load/start/wait-busy/wait-done with a guard against a silent transmitter.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(ACK_TIMEOUT);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t              state, state_nxt;
  logic [GW-1:0]       rr_ptr, rr_nxt, grant_q, grant_inc, winner;
  logic [DATA_W-1:0]   data_q;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic                any_vld;
  logic [NUM_REQ-1:0]  ready;
  logic                start, done, err;

  // Scan from the farthest slot back to rr_ptr so the last hit is the rr-ordered winner.
  always_comb begin
    logic [GW-1:0] idx;
    idx     = '0;
    winner  = rr_ptr;
    any_vld = 1'b0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      idx = GW'((int'(rr_ptr) + k) % NUM_REQ);
      if (bus.req_valid[idx]) begin
        winner  = idx;
        any_vld = 1'b1;
      end
    end
  end

  assign grant_inc = (grant_q == GW'(NUM_REQ-1)) ? '0 : grant_q + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      grant_q <= '0;
      data_q  <= '0;
      cnt     <= '0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_nxt;
      cnt    <= cnt_nxt;
      if (state == IDLE && any_vld) begin
        data_q  <= bus.req_data[int'(winner)*DATA_W +: DATA_W];
        grant_q <= winner;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    cnt_nxt   = cnt;
    ready     = '0;
    start     = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        if (any_vld) begin
          // Gated by reset so nothing looks accepted while the block is held in reset.
          ready[winner] = reset;
          state_nxt     = START;
        end
      end
      START: begin
        start     = 1'b1;
        cnt_nxt   = '0;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (cnt == CW'(ACK_TIMEOUT-1)) begin
          err       = 1'b1;
          rr_nxt    = grant_inc;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          done      = 1'b1;
          rr_nxt    = grant_inc;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.req_ready   = ready;
  assign bus.tx_data     = data_q;
  assign bus.tx_start    = start;
  assign bus.grant_id    = grant_q;
  assign bus.tx_done     = done;
  assign bus.err_timeout = err;
  assign bus.idle        = (state == IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a reference rr model predicts each accept,
// a transmitter model answers tx_start, and a negedge monitor checks every cycle.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();
  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef enum {M_IDLE, M_START, M_XFER} mph_t;
  mph_t ph;
  int   ptr, cur_id, cyc, start_cyc, n_done, n_err, busy_len, w, e;
  logic seen, ed, ee, r1_seen, auto_drop;
  logic [N-1:0] er;
  int   exp_q[$];
  int   log_q[$];
  int   ord[$];

  // Transmitter model: busy for busy_len cycles after each start; busy_len=0 means silent.
  initial begin
    int   rem;
    logic st;
    rem = 0;
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      st = bus.tx_start;
      @(posedge clk);
      #1;
      if (!reset) begin
        bus.tx_busy = 1'b0;
        rem = 0;
      end else if (rem > 0) begin
        rem--;
        if (rem == 0) bus.tx_busy = 1'b0;
      end else if (st && busy_len > 0) begin
        bus.tx_busy = 1'b1;
        rem = busy_len;
      end
    end
  end

  // Reference model and per-cycle checks.
  initial begin
    ph = M_IDLE; ptr = 0; cyc = 0; n_done = 0; n_err = 0; seen = 1'b0; r1_seen = 1'b0;
    cur_id = 0; start_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.req_ready[1]) r1_seen = 1'b1;
      if (!reset) begin
        chk("rst_idle",  32'(bus.idle), 1);
        chk("rst_ready", 32'(bus.req_ready), 0);
        chk("rst_start", 32'(bus.tx_start), 0);
        chk("rst_done",  32'(bus.tx_done), 0);
        chk("rst_err",   32'(bus.err_timeout), 0);
        chk("rst_data",  32'(bus.tx_data), 0);
        chk("rst_gid",   32'(bus.grant_id), 0);
        ph = M_IDLE; ptr = 0; exp_q.delete();
      end else begin
        case (ph)
          M_IDLE: begin
            w = -1;
            for (int k = 0; k < N; k++) begin
              int i;
              i = (ptr + k) % N;
              if (w < 0 && bus.req_valid[i]) w = i;
            end
            er = '0;
            if (w >= 0) er[w] = 1'b1;
            chk("ready",      32'(bus.req_ready), 32'(er));
            chk("idle",       32'(bus.idle), 1);
            chk("start_idle", 32'(bus.tx_start), 0);
            chk("done_idle",  32'(bus.tx_done), 0);
            chk("err_idle",   32'(bus.err_timeout), 0);
            if (w >= 0) begin
              exp_q.push_back((w << 8) | int'(bus.req_data[w*DW +: DW]));
              cur_id = w;
              ph = M_START;
            end
          end
          M_START: begin
            chk("start",       32'(bus.tx_start), 1);
            chk("ready_start", 32'(bus.req_ready), 0);
            chk("idle_start",  32'(bus.idle), 0);
            if (exp_q.size() == 0) begin
              chk("sb_empty", 0, 1);
            end else begin
              e = exp_q.pop_front();
              chk("gid",  32'(bus.grant_id), 32'(e >> 8));
              chk("data", 32'(bus.tx_data), 32'(e & 255));
            end
            log_q.push_back((int'(bus.grant_id) << 8) | int'(bus.tx_data));
            start_cyc = cyc;
            seen = 1'b0;
            ph = M_XFER;
          end
          default: begin
            chk("ready_xfer", 32'(bus.req_ready), 0);
            chk("start_xfer", 32'(bus.tx_start), 0);
            chk("idle_xfer",  32'(bus.idle), 0);
            ed = seen && !bus.tx_busy;
            ee = !seen && !bus.tx_busy && (cyc - start_cyc == TO);
            chk("tx_done", 32'(bus.tx_done), 32'(ed));
            chk("err_to",  32'(bus.err_timeout), 32'(ee));
            if (bus.tx_busy) seen = 1'b1;
            if (ed) n_done++;
            if (ee) n_err++;
            if (ed || ee) begin
              ptr = (cur_id + 1) % N;
              ph = M_IDLE;
            end
          end
        endcase
      end
    end
  end

  task automatic tick();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = bus.req_valid & bus.req_ready;
    @(posedge clk);
    #1;
    if (auto_drop) bus.req_valid = bus.req_valid & ~acc;
  endtask

  task automatic set_req(input int i, input logic [DW-1:0] d);
    bus.req_data[i*DW +: DW] = d;
    bus.req_valid[i] = 1'b1;
  endtask

  task automatic wait_xfers(input int target, input int budget, input string tag);
    int t;
    t = 0;
    while (n_done + n_err < target && t < budget) begin
      tick();
      t++;
    end
    chk(tag, 32'(n_done + n_err >= target), 1);
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_len"}, 32'(log_q.size()), 32'(ord.size()));
    for (int i = 0; i < ord.size(); i++)
      chk(tag, (i < log_q.size()) ? 32'(log_q[i]) : 32'hFFFF_FFFF, 32'(ord[i]));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    bus.req_valid = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    int base, d0, e0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    auto_drop = 1'b1;
    busy_len = 4;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // single requester 2
    log_q.delete();
    busy_len = int'($urandom_range(3, 10));
    base = n_done + n_err;
    set_req(2, 8'hA5);
    wait_xfers(base + 1, 60, "t1_wait");
    ord = '{32'h2A5};
    check_log("t1_log");

    // all four held valid: rr order with wrap
    do_reset();
    log_q.delete();
    auto_drop = 1'b0;
    busy_len = 3;
    for (int i = 0; i < N; i++) set_req(i, 8'(8'h10 + i));
    base = n_done + n_err;
    wait_xfers(base + 5, 200, "t2_wait");
    bus.req_valid = '0;
    auto_drop = 1'b1;
    ord = '{32'h010, 32'h111, 32'h212, 32'h313, 32'h010};
    check_log("t2_order");

    // silent transmitter: timeouts, then next requester
    do_reset();
    log_q.delete();
    busy_len = 0;
    d0 = n_done; e0 = n_err;
    set_req(0, 8'h30);
    set_req(1, 8'h31);
    wait_xfers(n_done + n_err + 2, 100, "t3_wait");
    chk("t3_errs",  32'(n_err - e0), 2);
    chk("t3_dones", 32'(n_done - d0), 0);
    ord = '{32'h030, 32'h131};
    check_log("t3_order");

    // 1 and 3 request while 1 transmits: 3 goes first
    do_reset();
    log_q.delete();
    busy_len = 8;
    base = n_done + n_err;
    set_req(1, 8'h41);
    repeat (3) tick();
    set_req(1, 8'h42);
    set_req(3, 8'h43);
    wait_xfers(base + 3, 150, "t4_wait");
    ord = '{32'h141, 32'h343, 32'h142};
    check_log("t4_order");

    // reset during WAIT_DONE
    do_reset();
    busy_len = 10;
    set_req(2, 8'h52);
    repeat (5) tick();
    set_req(0, 8'h50);
    #2 reset = 1'b0;
    #1;
    chk("t5_idle",  32'(bus.idle), 1);
    chk("t5_ready", 32'(bus.req_ready), 0);
    chk("t5_start", 32'(bus.tx_start), 0);
    chk("t5_done",  32'(bus.tx_done), 0);
    chk("t5_data",  32'(bus.tx_data), 0);
    chk("t5_gid",   32'(bus.grant_id), 0);
    @(posedge clk);
    @(posedge clk);
    log_q.delete();
    #1 reset = 1'b1;
    base = n_done + n_err;
    wait_xfers(base + 1, 60, "t5_wait");
    ord = '{32'h050};
    check_log("t5_first");

    // requester 1 withdraws before acceptance
    do_reset();
    log_q.delete();
    busy_len = 6;
    base = n_done + n_err;
    set_req(0, 8'h60);
    repeat (3) tick();
    r1_seen = 1'b0;
    set_req(1, 8'h61);
    set_req(2, 8'h62);
    repeat (2) tick();
    bus.req_valid[1] = 1'b0;
    wait_xfers(base + 2, 100, "t6_wait");
    ord = '{32'h060, 32'h262};
    check_log("t6_order");
    chk("t6_no_ready1", 32'(r1_seen), 0);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
